alu_issue_ctrl: RTL and testbench

Sequential initiator on the ALU operation interface. Accepts one MIPS instruction plus register-file operands through a valid/ready handshake and decodes it to the 4-bit ALU operation code, operands and shift amount. It drives these to the combinational ALU for one cycle and captures ALUResult/Zero. It then presents a write-back/branch result through a second valid/ready handshake. It sits between the register-read stage and the write-back/PC logic of the multi-cycle datapath.

---
 rtl/mips_alu_pkg.sv | 42 ++++
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_op_decode.sv | 91 +++++++++
 rtl/alu_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU op codes, MIPS opcode/funct
// constants, FSM states and instruction classes.
package mips_alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_NOR  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_NONE = 4'hF;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_e;

   typedef enum logic [1:0] {CLS_R_ALU, CLS_I_ALU, CLS_BRANCH, CLS_ILLEGAL} cls_e;

   typedef enum logic [1:0] {BSEL_RT, BSEL_SEXT, BSEL_ZEXT} bsel_e;

   function automatic logic cls_writes(cls_e c);
      return (c == CLS_R_ALU) || (c == CLS_I_ALU);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and write-back handshake bundle between the register-read
// stage, the ALU issue controller, the combinational ALU and write-back logic.
interface alu_issue_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [3:0]        ALUOperation;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [4:0]        shamt;
   logic [DATA_W-1:0] ALUResult;
   logic              Zero;
   logic              wb_valid;
   logic              wb_ready;
   logic              wb_write;
   logic [REG_AW-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              branch_taken;
   logic              illegal;

   modport master (
      input  instr_valid, instr, rs_data, rt_data, ALUResult, Zero, wb_ready,
      output instr_ready, ALUOperation, A, B, shamt,
             wb_valid, wb_write, wb_reg, wb_data, branch_taken, illegal
   );

   modport slave (
      output instr_valid, instr, rs_data, rt_data, ALUResult, Zero, wb_ready,
      input  instr_ready, ALUOperation, A, B, shamt,
             wb_valid, wb_write, wb_reg, wb_data, branch_taken, illegal
   );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: instruction word to ALU op, operand-B select,
// shift amount, destination register and instruction class.
module alu_op_decode
   import mips_alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  op,
   output bsel_e       bsel,
   output logic [4:0]  shamt,
   output logic [4:0]  dest,
   output cls_e        cls,
   output logic        br_ne,
   output logic        illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [3:0] r_op;
   logic       r_ok;
   logic       unused_rs;

   assign opcode    = instr[31:26];
   assign funct     = instr[5:0];
   assign rt        = instr[20:16];
   assign rd        = instr[15:11];
   assign unused_rs = ^instr[25:21];

   always_comb begin
      r_op = ALU_NONE;
      r_ok = 1'b1;
      case (funct)
         FN_AND:          r_op = ALU_AND;
         FN_OR:           r_op = ALU_OR;
         FN_NOR:          r_op = ALU_NOR;
         FN_ADD, FN_ADDU: r_op = ALU_ADD;
         FN_SUB, FN_SUBU: r_op = ALU_SUB;
         FN_SLL:          r_op = ALU_SLL;
         FN_SRL:          r_op = ALU_SRL;
         default:         r_ok = 1'b0;
      endcase
   end

   // Anything not explicitly matched falls through as illegal with ALU_NONE.
   always_comb begin
      op    = ALU_NONE;
      bsel  = BSEL_RT;
      shamt = '0;
      dest  = '0;
      cls   = CLS_ILLEGAL;
      br_ne = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (r_ok) begin
               op    = r_op;
               shamt = instr[10:6];
               dest  = rd;
               cls   = CLS_R_ALU;
            end
         end
         OP_ADDI, OP_ADDIU: begin
            op   = ALU_ADD;
            bsel = BSEL_SEXT;
            dest = rt;
            cls  = CLS_I_ALU;
         end
         OP_ANDI: begin
            op   = ALU_AND;
            bsel = BSEL_ZEXT;
            dest = rt;
            cls  = CLS_I_ALU;
         end
         OP_ORI: begin
            op   = ALU_OR;
            bsel = BSEL_ZEXT;
            dest = rt;
            cls  = CLS_I_ALU;
         end
         OP_BEQ, OP_BNE: begin
            op    = ALU_SUB;
            cls   = CLS_BRANCH;
            br_ne = opcode[0];
         end
         default: ;
      endcase
   end

   assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded MIPS instruction to the combinational ALU, captures the
// result and presents it for write-back / branch resolution.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | instr_ready=1, waiting for instr_valid; decode is registered
//   ST_EXEC | ALU inputs driven from registers; result captured at edge
//   ST_WB   | wb_valid=1, wb_* held until wb_ready
module alu_issue_ctrl
   import mips_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic             clk,
   input  logic             reset,
   alu_issue_ctrl_if.master bus
);

   state_e state_q, state_d;
   logic   accept, capture, instr_ready_d, wb_valid_d;

   logic [3:0] dec_op;
   bsel_e      dec_bsel;
   logic [4:0] dec_shamt;
   logic [4:0] dec_dest;
   cls_e       dec_cls;
   logic       dec_br_ne;
   logic       dec_illegal;

   logic [DATA_W-1:0] b_sel;

   logic [3:0]        alu_op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [4:0]        shamt_q;
   logic [4:0]        dest_q;
   cls_e              cls_q;
   logic              br_ne_q;
   logic              exec_ill_q;

   logic              wb_write_q;
   logic [REG_AW-1:0] wb_reg_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              branch_q;
   logic              illegal_q;
   logic              writes;

   alu_op_decode u_decode (
      .instr   (bus.instr),
      .op      (dec_op),
      .bsel    (dec_bsel),
      .shamt   (dec_shamt),
      .dest    (dec_dest),
      .cls     (dec_cls),
      .br_ne   (dec_br_ne),
      .illegal (dec_illegal)
   );

   always_comb begin
      case (dec_bsel)
         BSEL_SEXT: b_sel = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};
         BSEL_ZEXT: b_sel = {{(DATA_W-16){1'b0}}, bus.instr[15:0]};
         default:   b_sel = bus.rt_data;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      capture       = 1'b0;
      instr_ready_d = 1'b0;
      wb_valid_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready_d = 1'b1;
            if (bus.instr_valid) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            capture = 1'b1;
            state_d = ST_WB;
         end
         ST_WB: begin
            wb_valid_d = 1'b1;
            if (bus.wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_op_q   <= ALU_NONE;
         a_q        <= '0;
         b_q        <= '0;
         shamt_q    <= '0;
         dest_q     <= '0;
         cls_q      <= CLS_ILLEGAL;
         br_ne_q    <= 1'b0;
         exec_ill_q <= 1'b0;
      end else if (accept) begin
         alu_op_q   <= dec_op;
         a_q        <= bus.rs_data;
         b_q        <= b_sel;
         shamt_q    <= dec_shamt;
         dest_q     <= dec_dest;
         cls_q      <= dec_cls;
         br_ne_q    <= dec_br_ne;
         exec_ill_q <= dec_illegal;
      end
   end

   // $0 is never written, so a zero destination suppresses the write entirely.
   assign writes = cls_writes(cls_q) && (dest_q != 5'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_write_q <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
         branch_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (capture) begin
         wb_write_q <= writes;
         wb_reg_q   <= writes ? REG_AW'(dest_q) : '0;
         wb_data_q  <= exec_ill_q ? '0 : bus.ALUResult;
         branch_q   <= (cls_q == CLS_BRANCH) && (bus.Zero ^ br_ne_q);
         illegal_q  <= exec_ill_q;
      end
   end

   assign bus.instr_ready  = instr_ready_d;
   assign bus.wb_valid     = wb_valid_d;
   assign bus.ALUOperation = alu_op_q;
   assign bus.A            = a_q;
   assign bus.B            = b_q;
   assign bus.shamt        = shamt_q;
   assign bus.wb_write     = wb_write_q;
   assign bus.wb_reg       = wb_reg_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.branch_taken = branch_q;
   assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached to the
// interface; expected values are hand-computed per instruction.
module tb_alu_issue_ctrl;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   alu_issue_ctrl_if #(.DATA_W(32), .REG_AW(5)) bus ();

   alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] alu_res;
   always_comb begin
      case (bus.ALUOperation)
         4'd0:    alu_res = bus.A & bus.B;
         4'd1:    alu_res = bus.A | bus.B;
         4'd2:    alu_res = ~(bus.A | bus.B);
         4'd3:    alu_res = bus.A + bus.B;
         4'd4:    alu_res = bus.A - bus.B;
         4'd5:    alu_res = bus.B << bus.shamt;
         4'd6:    alu_res = bus.B >> bus.shamt;
         default: alu_res = 32'd0;
      endcase
   end
   assign bus.ALUResult = alu_res;
   assign bus.Zero      = (alu_res == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full IDLE -> EXEC -> WB -> IDLE pass; must be entered with the DUT in IDLE.
   task automatic run_op(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] e_op,
                         input logic [31:0] e_a, input logic [31:0] e_b,
                         input logic [4:0] e_sh, input logic e_wr, input logic [4:0] e_reg,
                         input logic [31:0] e_data, input logic e_br, input logic e_ill);
      bus.instr       = ins;
      bus.rs_data     = rs;
      bus.rt_data     = rt;
      bus.instr_valid = 1'b1;
      check({nm, ".idle_ready"}, 32'(bus.instr_ready), 32'd1);
      step();
      bus.instr_valid = 1'b0;
      check({nm, ".exec_op"}, 32'(bus.ALUOperation), 32'(e_op));
      check({nm, ".exec_a"}, bus.A, e_a);
      check({nm, ".exec_b"}, bus.B, e_b);
      check({nm, ".exec_shamt"}, 32'(bus.shamt), 32'(e_sh));
      check({nm, ".exec_ready"}, 32'(bus.instr_ready), 32'd0);
      check({nm, ".exec_wbv"}, 32'(bus.wb_valid), 32'd0);
      step();
      check({nm, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
      check({nm, ".wb_write"}, 32'(bus.wb_write), 32'(e_wr));
      check({nm, ".wb_reg"}, 32'(bus.wb_reg), 32'(e_reg));
      check({nm, ".wb_data"}, bus.wb_data, e_data);
      check({nm, ".branch"}, 32'(bus.branch_taken), 32'(e_br));
      check({nm, ".illegal"}, 32'(bus.illegal), 32'(e_ill));
      bus.wb_ready = 1'b1;
      step();
      bus.wb_ready = 1'b0;
      check({nm, ".back_idle_wbv"}, 32'(bus.wb_valid), 32'd0);
      check({nm, ".back_idle_ready"}, 32'(bus.instr_ready), 32'd1);
   endtask

   initial begin
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'd0;
      bus.rs_data     = 32'd0;
      bus.rt_data     = 32'd0;
      bus.wb_ready    = 1'b0;
      #1 reset = 1'b0;
      step();
      step();
      check("rst.ready", 32'(bus.instr_ready), 32'd1);
      check("rst.wbv", 32'(bus.wb_valid), 32'd0);
      check("rst.op", 32'(bus.ALUOperation), 32'hF);
      check("rst.a", bus.A, 32'd0);
      check("rst.b", bus.B, 32'd0);
      check("rst.shamt", 32'(bus.shamt), 32'd0);
      check("rst.wr", 32'(bus.wb_write), 32'd0);
      check("rst.reg", 32'(bus.wb_reg), 32'd0);
      check("rst.data", bus.wb_data, 32'd0);
      check("rst.br", 32'(bus.branch_taken), 32'd0);
      check("rst.ill", 32'(bus.illegal), 32'd0);
      reset = 1'b1;
      step();

      //      name    instr                                         rs             rt            op     A              B             sh    wr    reg    data          br    ill
      run_op("add",  {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20},      32'd5,         32'd7,        4'd3, 32'd5,         32'd7,        5'd0, 1'b1, 5'd3,  32'd12,       1'b0, 1'b0);
      run_op("sll",  {6'h00, 5'd0, 5'd2, 5'd4, 5'd4, 6'h00},      32'd0,         32'd1,        4'd5, 32'd0,         32'd1,        5'd4, 1'b1, 5'd4,  32'h10,       1'b0, 1'b0);
      run_op("srl",  {6'h00, 5'd0, 5'd2, 5'd5, 5'd3, 6'h02},      32'd0,         32'h80,       4'd6, 32'd0,         32'h80,       5'd3, 1'b1, 5'd5,  32'h10,       1'b0, 1'b0);
      run_op("sub",  {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22},      32'd20,        32'd8,        4'd4, 32'd20,        32'd8,        5'd0, 1'b1, 5'd9,  32'd12,       1'b0, 1'b0);
      run_op("nor",  {6'h00, 5'd1, 5'd2, 5'd10, 5'd0, 6'h27},     32'hF0F0_0000, 32'h0F0F_0000, 4'd2, 32'hF0F0_0000, 32'h0F0F_0000, 5'd0, 1'b1, 5'd10, 32'h0000_FFFF, 1'b0, 1'b0);
      run_op("ori",  {6'h0D, 5'd1, 5'd6, 16'h8000},               32'h0000_0F00, 32'h0000_DEAD, 4'd1, 32'h0000_0F00, 32'h0000_8000, 5'd0, 1'b1, 5'd6,  32'h0000_8F00, 1'b0, 1'b0);
      run_op("andi", {6'h0C, 5'd1, 5'd8, 16'hFF0F},               32'h1234_5678, 32'd0,        4'd0, 32'h1234_5678, 32'h0000_FF0F, 5'd0, 1'b1, 5'd8,  32'h0000_5608, 1'b0, 1'b0);
      run_op("addi", {6'h08, 5'd1, 5'd7, 16'hFFFF},               32'd10,        32'd0,        4'd3, 32'd10,        32'hFFFF_FFFF, 5'd0, 1'b1, 5'd7,  32'd9,        1'b0, 1'b0);
      run_op("beq_t", {6'h04, 5'd1, 5'd2, 16'h0003},              32'd9,         32'd9,        4'd4, 32'd9,         32'd9,        5'd0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0);
      run_op("bne_n", {6'h05, 5'd1, 5'd2, 16'h0003},              32'd9,         32'd9,        4'd4, 32'd9,         32'd9,        5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0);
      run_op("bne_t", {6'h05, 5'd1, 5'd2, 16'h0003},              32'd9,         32'd4,        4'd4, 32'd9,         32'd4,        5'd0, 1'b0, 5'd0,  32'd5,        1'b1, 1'b0);
      run_op("beq_n", {6'h04, 5'd1, 5'd2, 16'h0003},              32'd9,         32'd4,        4'd4, 32'd9,         32'd4,        5'd0, 1'b0, 5'd0,  32'd5,        1'b0, 1'b0);
      run_op("ill_op", {6'h3F, 26'd0},                            32'd0,         32'd0,        4'hF, 32'd0,         32'd0,        5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1);
      run_op("ill_fn", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A},    32'd0,         32'd0,        4'hF, 32'd0,         32'd0,        5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1);
      run_op("add_r0", {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20},    32'd5,         32'd7,        4'd3, 32'd5,         32'd7,        5'd0, 1'b0, 5'd0,  32'd12,       1'b0, 1'b0);

      // Back-pressure: instr_valid stays high throughout and inputs change mid-flight.
      bus.instr       = {6'h00, 5'd1, 5'd2, 5'd11, 5'd0, 6'h20};
      bus.rs_data     = 32'd100;
      bus.rt_data     = 32'd1;
      bus.instr_valid = 1'b1;
      step();
      bus.instr   = {6'h00, 5'd1, 5'd2, 5'd12, 5'd0, 6'h22};
      bus.rs_data = 32'd0;
      #1;
      check("hold.exec_op", 32'(bus.ALUOperation), 32'd3);
      check("hold.exec_a", bus.A, 32'd100);
      step();
      for (int i = 0; i < 5; i++) begin
         check("hold.wbv", 32'(bus.wb_valid), 32'd1);
         check("hold.ready", 32'(bus.instr_ready), 32'd0);
         check("hold.data", bus.wb_data, 32'd101);
         check("hold.reg", 32'(bus.wb_reg), 32'd11);
         check("hold.wr", 32'(bus.wb_write), 32'd1);
         step();
      end
      bus.wb_ready = 1'b1;
      step();
      bus.wb_ready = 1'b0;
      check("b2b.idle_ready", 32'(bus.instr_ready), 32'd1);
      check("b2b.idle_wbv", 32'(bus.wb_valid), 32'd0);
      step();
      bus.instr_valid = 1'b0;
      check("b2b.exec_op", 32'(bus.ALUOperation), 32'd4);
      check("b2b.exec_a", bus.A, 32'd0);
      check("b2b.exec_b", bus.B, 32'd1);
      bus.wb_ready = 1'b1;
      step();
      check("early_rdy.wbv", 32'(bus.wb_valid), 32'd1);
      check("early_rdy.data", bus.wb_data, 32'hFFFF_FFFF);
      check("early_rdy.reg", 32'(bus.wb_reg), 32'd12);
      step();
      bus.wb_ready = 1'b0;
      check("early_rdy.idle_wbv", 32'(bus.wb_valid), 32'd0);
      check("early_rdy.idle_ready", 32'(bus.instr_ready), 32'd1);

      // Reset asserted while an instruction is in EXEC.
      bus.instr       = {6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20};
      bus.rs_data     = 32'd1;
      bus.rt_data     = 32'd2;
      bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      check("rexec.op_before", 32'(bus.ALUOperation), 32'd3);
      reset = 1'b0;
      #1;
      check("rexec.ready", 32'(bus.instr_ready), 32'd1);
      check("rexec.wbv", 32'(bus.wb_valid), 32'd0);
      check("rexec.op", 32'(bus.ALUOperation), 32'hF);
      check("rexec.a", bus.A, 32'd0);
      check("rexec.b", bus.B, 32'd0);
      step();
      step();
      check("rexec.wbv_held", 32'(bus.wb_valid), 32'd0);
      check("rexec.data", bus.wb_data, 32'd0);
      reset = 1'b1;
      step();
      check("rexec.post_wbv", 32'(bus.wb_valid), 32'd0);
      check("rexec.post_ready", 32'(bus.instr_ready), 32'd1);
      step();
      check("rexec.post_wbv2", 32'(bus.wb_valid), 32'd0);
      run_op("post_rst", {6'h00, 5'd1, 5'd2, 5'd14, 5'd0, 6'h20}, 32'd2, 32'd3,
             4'd3, 32'd2, 32'd3, 5'd0, 1'b1, 5'd14, 32'd5, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
